// File: rtl/ef_pkg.sv
// Shared definitions for the extremum-finder shift autoranger: controller states,
// shift limit, EF threshold reset constants and the window-length helper.
package ef_pkg;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_SETTLE   = 2'd1,
    ST_TRACK    = 2'd2
  } ef_state_e;

  localparam logic [2:0] SHIFT_MAX = 3'd7;

  // Threshold values the EF presents straight out of reset (16-bit samples).
  localparam logic [15:0] EF_LOWER_RESET = 16'h7FFF;
  localparam logic [15:0] EF_UPPER_RESET = 16'h8000;

  // Last measure phase of a window of log2 length log_count.
  function automatic logic [31:0] ef_window_last(input logic [4:0] log_count);
    return 32'd1 << log_count;
  endfunction

endpackage

// File: rtl/ef_shift_autoranger_window_phase.sv
// EF window phase tracker: phase 0 is the EF idle cycle, phases 1..2^L measure.
// The window length is latched at the end of phase 0 and held for that window.
module ef_window_phase
  import ef_pkg::*;
(
  input  logic       aclk,
  input  logic       aresetn,
  input  logic [4:0] log_count_i,
  output logic       boundary_o,
  output logic [4:0] log_count_o
);

  logic [31:0] phase_q, phase_d;
  logic [4:0]  log_q, log_d;

  always_comb begin
    log_d   = log_q;
    phase_d = phase_q + 32'd1;
    if (phase_q == 32'd0) begin
      log_d = log_count_i;
    end else if (phase_q == ef_window_last(log_q)) begin
      phase_d = 32'd0;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      phase_q <= 32'd0;
      log_q   <= log_count_i;
    end else begin
      phase_q <= phase_d;
      log_q   <= log_d;
    end
  end

  assign boundary_o  = (phase_q == 32'd0);
  assign log_count_o = log_q;

endmodule

// File: rtl/ef_shift_autoranger.sv
// Closed-loop EF_shift controller for the extremum finder; keeps the threshold span
// inside [cfg_span_low, cfg_span_high]. Optional manual override: EF_SHIFT_AUTORANGER_MANUAL_EN.
module ef_shift_autoranger
  import ef_pkg::*;
#(
  parameter int         DATA_WIDTH = 16,
  parameter logic [2:0] SHIFT_INIT = 3'd0,
  parameter int         LOCK_COUNT = 4
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  cfg_enable,
  input  logic [4:0]            cfg_log_count,
  input  logic [DATA_WIDTH-1:0] cfg_span_low,
  input  logic [DATA_WIDTH-1:0] cfg_span_high,
  input  logic [3:0]            cfg_settle,
`ifdef EF_SHIFT_AUTORANGER_MANUAL_EN
  input  logic                  cfg_manual,
  input  logic [2:0]            cfg_manual_shift,
`endif
  input  logic [DATA_WIDTH-1:0] EF_lower_threshold,
  input  logic [DATA_WIDTH-1:0] EF_upper_threshold,
  output logic [4:0]            EF_log_count,
  output logic [2:0]            EF_shift,
  output logic                  ctrl_locked,
  output logic [15:0]           ctrl_adjust_count
);

  localparam logic [3:0] LOCK_MAX = 4'(LOCK_COUNT);

  ef_state_e   state_q;
  logic [2:0]  shift_q;
  logic [3:0]  settle_q;
  logic [3:0]  lock_q;
  logic        locked_q;
  logic [15:0] adj_q;

  logic        boundary;
  logic        log_change;
  logic        manual_on;
  logic [2:0]  manual_shift;
  logic [15:0] adj_inc;

  logic signed [DATA_WIDTH:0] span;
  logic                       span_neg;
  logic                       above;
  logic                       below;

  ef_window_phase u_phase (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .log_count_i (cfg_log_count),
    .boundary_o  (boundary),
    .log_count_o (EF_log_count)
  );

`ifdef EF_SHIFT_AUTORANGER_MANUAL_EN
  assign manual_on    = cfg_manual;
  assign manual_shift = cfg_manual_shift;
`else
  assign manual_on    = 1'b0;
  assign manual_shift = SHIFT_INIT;
`endif

  // Sign-extended difference cannot overflow DATA_WIDTH+1 bits; a non-negative span fits DATA_WIDTH bits.
  assign span     = $signed({EF_upper_threshold[DATA_WIDTH-1], EF_upper_threshold})
                  - $signed({EF_lower_threshold[DATA_WIDTH-1], EF_lower_threshold});
  assign span_neg = span[DATA_WIDTH];
  assign above    = !span_neg && (span[DATA_WIDTH-1:0] > cfg_span_high);
  assign below    = !span_neg && (span[DATA_WIDTH-1:0] < cfg_span_low);

  assign log_change = boundary && (cfg_log_count != EF_log_count);
  assign adj_inc    = (adj_q == 16'hFFFF) ? adj_q : adj_q + 16'd1;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q  <= ST_DISABLED;
      shift_q  <= SHIFT_INIT;
      settle_q <= 4'd0;
      lock_q   <= 4'd0;
      locked_q <= 1'b0;
      adj_q    <= 16'd0;
    end else if (!cfg_enable) begin
      state_q  <= ST_DISABLED;
      lock_q   <= 4'd0;
      locked_q <= 1'b0;
    end else if (manual_on) begin
      lock_q   <= 4'd0;
      locked_q <= 1'b0;
      if (state_q == ST_DISABLED) begin
        state_q  <= ST_SETTLE;
        settle_q <= cfg_settle;
      end else if (boundary && (manual_shift != shift_q)) begin
        shift_q  <= manual_shift;
        state_q  <= ST_SETTLE;
        settle_q <= cfg_settle;
      end
    end else begin
      case (state_q)
        ST_DISABLED: begin
          state_q  <= ST_SETTLE;
          settle_q <= cfg_settle;
        end
        ST_SETTLE: if (boundary) begin
          if (log_change) begin
            settle_q <= cfg_settle;
            lock_q   <= 4'd0;
            locked_q <= 1'b0;
          end else if (settle_q == 4'd0) begin
            state_q <= ST_TRACK;
          end else begin
            settle_q <= settle_q - 4'd1;
          end
        end
        ST_TRACK: if (boundary) begin
          if (log_change) begin
            state_q  <= ST_SETTLE;
            settle_q <= cfg_settle;
            lock_q   <= 4'd0;
            locked_q <= 1'b0;
          end else if (span_neg) begin
            lock_q   <= 4'd0;
            locked_q <= 1'b0;
          end else if (above || below) begin
            // High test has priority so a misconfigured band never steps down here.
            lock_q   <= 4'd0;
            locked_q <= 1'b0;
            if (above && (shift_q != SHIFT_MAX)) begin
              shift_q  <= shift_q + 3'd1;
              adj_q    <= adj_inc;
              state_q  <= ST_SETTLE;
              settle_q <= cfg_settle;
            end else if (!above && (shift_q != 3'd0)) begin
              shift_q  <= shift_q - 3'd1;
              adj_q    <= adj_inc;
              state_q  <= ST_SETTLE;
              settle_q <= cfg_settle;
            end
          end else if (lock_q != LOCK_MAX) begin
            lock_q   <= lock_q + 4'd1;
            locked_q <= ((lock_q + 4'd1) == LOCK_MAX);
          end
        end
        default: state_q <= ST_DISABLED;
      endcase
    end
  end

  assign EF_shift          = shift_q;
  assign ctrl_locked       = locked_q;
  assign ctrl_adjust_count = adj_q;

endmodule

// File: tb/tb_ef_shift_autoranger.sv
// Self-checking bench for ef_shift_autoranger: a window-level reference model runs
// alongside the DUT and every output is compared on each falling edge.
`timescale 1ns/1ps
module tb_ef_shift_autoranger;
  import ef_pkg::*;

  localparam int DW         = 16;
  localparam int LOCK_COUNT = 4;
  localparam int SHIFT_INIT = 0;

  // ---------------- clock / reset ----------------
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic          cfg_enable;
  logic [4:0]    cfg_log_count;
  logic [DW-1:0] cfg_span_low, cfg_span_high;
  logic [3:0]    cfg_settle;
  logic [DW-1:0] ef_lower, ef_upper;
  logic [4:0]    ef_log_count;
  logic [2:0]    ef_shift;
  logic          ctrl_locked;
  logic [15:0]   ctrl_adjust_count;

  int checks = 0;
  int errors = 0;

  ef_shift_autoranger #(
    .DATA_WIDTH (DW),
    .SHIFT_INIT (3'(SHIFT_INIT)),
    .LOCK_COUNT (LOCK_COUNT)
  ) dut (
    .aclk               (aclk),
    .aresetn            (aresetn),
    .cfg_enable         (cfg_enable),
    .cfg_log_count      (cfg_log_count),
    .cfg_span_low       (cfg_span_low),
    .cfg_span_high      (cfg_span_high),
    .cfg_settle         (cfg_settle),
    .EF_lower_threshold (ef_lower),
    .EF_upper_threshold (ef_upper),
    .EF_log_count       (ef_log_count),
    .EF_shift           (ef_shift),
    .ctrl_locked        (ctrl_locked),
    .ctrl_adjust_count  (ctrl_adjust_count)
  );

  // ---------------- reference model ----------------
  // m_skip: window boundaries still to ignore before the next span evaluation.
  int m_phase, m_log, m_shift, m_lock, m_adj, m_skip;
  bit m_en;
  bit m_valid = 1'b0;

  task automatic m_changed();
    m_lock = 0;
    m_skip = int'(cfg_settle) + 1;
  endtask

  task automatic m_evaluate();
    int span, lo, hi;
    span = int'($signed(ef_upper)) - int'($signed(ef_lower));
    lo   = int'(cfg_span_low);
    hi   = int'(cfg_span_high);
    if (span < 0) m_lock = 0;
    else if (span > hi) begin
      if (m_shift < 7) begin
        m_shift++;
        m_adj = (m_adj < 65535) ? m_adj + 1 : m_adj;
        m_changed();
      end else m_lock = 0;
    end else if (span < lo) begin
      if (m_shift > 0) begin
        m_shift--;
        m_adj = (m_adj < 65535) ? m_adj + 1 : m_adj;
        m_changed();
      end else m_lock = 0;
    end else if (m_lock < LOCK_COUNT) m_lock++;
  endtask

  task automatic m_step();
    bit at_boundary;
    at_boundary = (m_phase == 0);
    if (!cfg_enable) begin
      m_en   = 1'b0;
      m_lock = 0;
    end else if (!m_en) begin
      m_en   = 1'b1;
      m_skip = int'(cfg_settle) + 1;
    end else if (at_boundary) begin
      if (int'(cfg_log_count) != m_log) m_changed();
      else if (m_skip > 0) m_skip--;
      else m_evaluate();
    end
    if (at_boundary) m_log = int'(cfg_log_count);
    m_phase = (m_phase + 1) % ((1 << m_log) + 1);
  endtask

  initial forever begin
    @(posedge aclk);
    if (!aresetn) begin
      m_phase = 0; m_log = int'(cfg_log_count); m_shift = SHIFT_INIT;
      m_lock = 0; m_adj = 0; m_skip = 0; m_en = 1'b0; m_valid = 1'b1;
    end else m_step();
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge aclk);
    if (m_valid) begin
      check("log_count", 32'(ef_log_count), m_log);
      check("shift", 32'(ef_shift), m_shift);
      check("locked", 32'(ctrl_locked), int'(m_lock == LOCK_COUNT));
      check("adjust_count", 32'(ctrl_adjust_count), m_adj);
    end
  end

  // ---------------- EF threshold driver ----------------
  // Thresholds change in the idle cycle and reflect the shift of the window just measured.
  int ef_mode = 2;
  int forced_span = 5000;

  initial begin
    ef_lower = EF_LOWER_RESET;
    ef_upper = EF_UPPER_RESET;
    forever begin
      @(negedge aclk);
      if (m_valid && aresetn && m_phase == 0) begin
        int a, lo, sp;
        case (ef_mode)
          0: begin
            a = 1000 >> m_shift;
            ef_lower = DW'(-a);
            ef_upper = DW'(a);
          end
          1: begin
            ef_lower = '0;
            ef_upper = DW'(forced_span);
          end
          3: begin
            if ($urandom_range(0, 9) == 0) begin
              ef_lower = EF_LOWER_RESET;
              ef_upper = EF_UPPER_RESET;
            end else begin
              lo = $urandom_range(0, 400);
              lo = lo - 200;
              sp = $urandom_range(0, 700);
              sp = sp - 50;
              ef_lower = DW'(lo);
              ef_upper = DW'(lo + sp);
            end
          end
          default: begin
            ef_lower = EF_LOWER_RESET;
            ef_upper = EF_UPPER_RESET;
          end
        endcase
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge aclk);
  endtask

  task automatic wait_phase(input int p);
    int n;
    n = 0;
    while (m_phase != p && n < 200) begin
      @(negedge aclk);
      n++;
    end
    checks++;
    if (m_phase != p) begin
      errors++;
      $display("FAIL wait_phase: got phase %0d expected %0d (timeout)", m_phase, p);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    cfg_enable    = 1'b1;
    cfg_log_count = 5'd4;
    cfg_span_low  = DW'(100);
    cfg_span_high = DW'(300);
    cfg_settle    = 4'd1;
    ef_mode       = 0;
    aresetn       = 1'b0;
    cycles(3);
    aresetn = 1'b1;
    cycles(1);
    check("lit_reset_shift", 32'(ef_shift), 0);
    check("lit_reset_locked", 32'(ctrl_locked), 0);
    check("lit_reset_log", 32'(ef_log_count), 4);
    check("lit_reset_phase_model", 32'(m_phase), 1);

    // Span 2000 -> 1000 -> 500 -> 250 as the shift climbs to 3, then lock.
    cycles(20 * 17);
    check("lit_sine_shift", 32'(ef_shift), 3);
    check("lit_sine_adjust", 32'(ctrl_adjust_count), 3);
    check("lit_sine_locked", 32'(ctrl_locked), 1);

    // Window length change requested mid-window.
    wait_phase(8);
    cfg_log_count = 5'd6;
    cycles(1);
    check("lit_log_hold", 32'(ef_log_count), 4);
    cycles(70);
    check("lit_log_new", 32'(ef_log_count), 6);
    check("lit_log_unlocked", 32'(ctrl_locked), 0);
    cycles(12 * 65);
    check("lit_log_relock", 32'(ctrl_locked), 1);
    cfg_log_count = 5'd4;
    cycles(65 + 20 * 17);
    check("lit_back_relock", 32'(ctrl_locked), 1);

    // Disable mid-window; shift must freeze even with an out-of-band span.
    wait_phase(5);
    cfg_enable = 1'b0;
    cycles(1);
    check("lit_dis_locked", 32'(ctrl_locked), 0);
    ef_mode = 1;
    cycles(60);
    check("lit_dis_shift", 32'(ef_shift), 3);
    check("lit_dis_adjust", 32'(ctrl_adjust_count), 3);
    cfg_enable = 1'b1;

    // Span 5000 pushes the shift into saturation.
    cycles(20 * 17);
    check("lit_sat_shift", 32'(ef_shift), 7);
    check("lit_sat_adjust", 32'(ctrl_adjust_count), 7);
    check("lit_sat_locked", 32'(ctrl_locked), 0);
    cycles(6 * 17);
    check("lit_sat_hold", 32'(ctrl_adjust_count), 7);

    // EF reset thresholds: negative span, must not step down.
    ef_mode = 2;
    cycles(8 * 17);
    check("lit_neg_shift", 32'(ef_shift), 7);
    check("lit_neg_adjust", 32'(ctrl_adjust_count), 7);

    // Randomized configuration and threshold traffic.
    ef_mode = 3;
    for (int i = 0; i < 150; i++) begin
      cycles($urandom_range(1, 40));
      case ($urandom_range(0, 9))
        0: cfg_enable = ($urandom_range(0, 3) != 0);
        1: cfg_log_count = 5'($urandom_range(2, 5));
        2: cfg_settle = 4'($urandom_range(0, 3));
        3: begin
          cfg_span_low  = DW'($urandom_range(0, 400));
          cfg_span_high = DW'($urandom_range(0, 400));
        end
        default: ;
      endcase
    end
    cfg_enable = 1'b1;
    cycles(200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
